// File: rtl/quiz_pkg.sv
// Shared definitions for the factorization quiz game sequencer.
// State codes, judgement codes and the timer width helper.
package quiz_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned HP_W    = 4;
  localparam int unsigned QIDX_W  = 8;
  localparam int unsigned JUDG_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_Q = 3'd1,
    ST_INPUT  = 3'd2,
    ST_JUDGE  = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5
  } state_e;

  localparam logic [JUDG_W-1:0] JUDG_OK = 2'b01;
  localparam logic [JUDG_W-1:0] JUDG_NG = 2'b10;

  // Bits needed to hold a countdown from limit down to 0.
  function automatic int unsigned timer_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with ripple carry between digits.
// Holds at all nines instead of wrapping; clr has priority over inc.
module bcd_counter #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   q
);

  logic [4*DIGITS-1:0] q_q;
  logic [4*DIGITS-1:0] q_d;
  logic [DIGITS-1:0]   is_nine;
  logic                carry;

  // Carry ripples upward while the lower digit rolls from 9 to 0.
  always_comb begin
    q_d     = q_q;
    is_nine = '0;
    for (int i = 0; i < DIGITS; i++) begin
      is_nine[i] = (q_q[4*i +: 4] == 4'd9);
    end
    carry = inc & ~(&is_nine);
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        q_d[4*i +: 4] = is_nine[i] ? 4'd0 : q_q[4*i +: 4] + 4'd1;
        carry         = is_nine[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/quiz_seq.sv
// Game sequencer for the factorization quiz: question flow, answer timeout,
// hit points, BCD score and win/lose indication.
module quiz_seq
  import quiz_pkg::*;
#(
  parameter int unsigned NUM_Q      = 9,
  parameter int unsigned HP_INIT    = 3,
  parameter int unsigned CNT_DIGITS = 3,
  parameter int unsigned TIME_LIMIT = 1000
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic                                       READY,
  input  logic                                       QUE,
  input  logic                                       DEC,
  input  logic [JUDG_W-1:0]                          JUDG,
  input  logic                                       CLR,
  output logic [STATE_W-1:0]                         STATE,
  output logic [HP_W-1:0]                            HP,
  output logic [QIDX_W-1:0]                          Q_IDX,
  output logic [4*CNT_DIGITS-1:0]                    COUNT_OUT,
  output logic [timer_width(TIME_LIMIT)-1:0]         TIMER,
  output logic                                       LED,
  output logic                                       GAME_OVER
);

  localparam int unsigned TW = timer_width(TIME_LIMIT);

  state_e             state_q;
  logic [HP_W-1:0]    hp_q;
  logic [HP_W-1:0]    hp_d;
  logic [QIDX_W-1:0]  q_idx_q;
  logic [QIDX_W-1:0]  q_idx_d;
  logic [TW-1:0]      timer_q;
  logic               ok_q;
  logic               led_q;
  logic               game_over_q;
  logic               cnt_clr;
  logic               cnt_inc;

  // Values the JUDGE cycle commits; hit points floor at zero.
  always_comb begin
    hp_d    = hp_q;
    q_idx_d = q_idx_q + QIDX_W'(1);
    cnt_clr = CLR | ((state_q == ST_IDLE) & READY);
    cnt_inc = ~CLR & (state_q == ST_JUDGE) & ok_q;
    if (!ok_q && (hp_q != '0)) begin
      hp_d = hp_q - HP_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      hp_q        <= '0;
      q_idx_q     <= '0;
      timer_q     <= '0;
      ok_q        <= 1'b0;
      led_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else if (CLR) begin
      state_q     <= ST_IDLE;
      hp_q        <= '0;
      q_idx_q     <= '0;
      timer_q     <= '0;
      ok_q        <= 1'b0;
      led_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (READY) begin
            state_q <= ST_WAIT_Q;
            hp_q    <= HP_W'(HP_INIT);
            q_idx_q <= '0;
          end
        end
        ST_WAIT_Q: begin
          if (QUE) begin
            state_q <= ST_INPUT;
            timer_q <= TW'(TIME_LIMIT);
          end
        end
        ST_INPUT: begin
          // A submitted answer beats a simultaneous timeout.
          if (DEC) begin
            ok_q    <= (JUDG == JUDG_OK);
            state_q <= ST_JUDGE;
            timer_q <= '0;
          end else if (timer_q == TW'(1)) begin
            ok_q    <= 1'b0;
            state_q <= ST_JUDGE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_JUDGE: begin
          hp_q    <= hp_d;
          q_idx_q <= q_idx_d;
          if (hp_d == '0) begin
            state_q     <= ST_LOSE;
            game_over_q <= 1'b1;
          end else if (q_idx_d == QIDX_W'(NUM_Q)) begin
            state_q <= ST_WIN;
            led_q   <= 1'b1;
          end else begin
            state_q <= ST_WAIT_Q;
          end
        end
        ST_WIN, ST_LOSE: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  bcd_counter #(
    .DIGITS (CNT_DIGITS)
  ) u_score (
    .CLK (CLK),
    .RST (RST),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (COUNT_OUT)
  );

  assign STATE     = state_q;
  assign HP        = hp_q;
  assign Q_IDX     = q_idx_q;
  assign TIMER     = timer_q;
  assign LED       = led_q;
  assign GAME_OVER = game_over_q;

endmodule

// File: tb/tb_quiz_seq.sv
// Self-checking bench for quiz_seq: directed game scenarios plus random
// stimulus against a game-level reference model, and a score saturation run.
module tb_quiz_seq;
  import quiz_pkg::*;

  localparam int unsigned NQ  = 3;
  localparam int unsigned HPI = 2;
  localparam int unsigned CD  = 2;
  localparam int unsigned TL  = 8;
  localparam int unsigned TW  = timer_width(TL);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         ready, que, dec, clr;
  logic [1:0]   judg;
  logic [2:0]   state_o;
  logic [3:0]   hp_o;
  logic [7:0]   q_idx_o;
  logic [4*CD-1:0] count_o;
  logic [TW-1:0]   timer_o;
  logic         led_o, go_o;

  logic         s_ready, s_que, s_dec, s_clr;
  logic [1:0]   s_judg;
  logic [2:0]   s_state;
  logic [3:0]   s_hp;
  logic [7:0]   s_q_idx;
  logic [7:0]   s_count;
  logic [TW-1:0] s_timer;
  logic         s_led, s_go;

  quiz_seq #(.NUM_Q(NQ), .HP_INIT(HPI), .CNT_DIGITS(CD), .TIME_LIMIT(TL)) u_dut (
    .CLK(clk), .RST(rst), .READY(ready), .QUE(que), .DEC(dec), .JUDG(judg), .CLR(clr),
    .STATE(state_o), .HP(hp_o), .Q_IDX(q_idx_o), .COUNT_OUT(count_o), .TIMER(timer_o),
    .LED(led_o), .GAME_OVER(go_o)
  );

  quiz_seq #(.NUM_Q(120), .HP_INIT(1), .CNT_DIGITS(2), .TIME_LIMIT(TL)) u_sat (
    .CLK(clk), .RST(rst), .READY(s_ready), .QUE(s_que), .DEC(s_dec), .JUDG(s_judg), .CLR(s_clr),
    .STATE(s_state), .HP(s_hp), .Q_IDX(s_q_idx), .COUNT_OUT(s_count), .TIMER(s_timer),
    .LED(s_led), .GAME_OVER(s_go)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game-level reference: integer score, hit points and countdown.
  int m_state, m_hp, m_q, m_score, m_timer;
  bit m_ok, m_led, m_go;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_hp = 0; m_q = 0; m_score = 0; m_timer = 0;
    m_ok = 1'b0; m_led = 1'b0; m_go = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit qu, input bit de, input logic [1:0] jd, input bit cl);
    if (cl) begin
      model_reset();
    end else begin
      case (m_state)
        0: if (r) begin m_state = 1; m_hp = HPI; m_q = 0; m_score = 0; end
        1: if (qu) begin m_state = 2; m_timer = TL; end
        2: begin
          if (de) begin
            m_ok = (jd == 2'b01); m_state = 3; m_timer = 0;
          end else if (m_timer == 1) begin
            m_ok = 1'b0; m_state = 3; m_timer = 0;
          end else begin
            m_timer--;
          end
        end
        3: begin
          if (m_ok) m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
          else if (m_hp > 0) m_hp--;
          m_q++;
          if (m_hp == 0) begin m_state = 5; m_go = 1'b1; end
          else if (m_q == NQ) begin m_state = 4; m_led = 1'b1; end
          else m_state = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("state", 32'(state_o), 32'(m_state));
    check_eq("hp",    32'(hp_o),    32'(m_hp));
    check_eq("q_idx", 32'(q_idx_o), 32'(m_q));
    check_eq("count", 32'(count_o), to_bcd(m_score));
    check_eq("timer", 32'(timer_o), 32'(m_timer));
    check_eq("led",   32'(led_o),   32'(m_led));
    check_eq("over",  32'(go_o),    32'(m_go));
  endtask

  task automatic step(input bit r, input bit qu, input bit de, input logic [1:0] jd, input bit cl);
    ready = r; que = qu; dec = de; judg = jd; clr = cl;
    @(posedge clk);
    model_step(r, qu, de, jd, cl);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic answer(input logic [1:0] jd);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b1, jd, 1'b0);
    idle();
  endtask

  task automatic s_step(input bit r, input bit qu, input bit de, input logic [1:0] jd);
    s_ready = r; s_que = qu; s_dec = de; s_judg = jd; s_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b0; que = 1'b0; dec = 1'b0; judg = 2'b00; clr = 1'b0;
    s_ready = 1'b0; s_que = 1'b0; s_dec = 1'b0; s_judg = 2'b00; s_clr = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Perfect game, then READY held in WIN must not restart.
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (3) answer(2'b01);
    check_eq("perfect_count", 32'(count_o), 32'h03);
    check_eq("perfect_hp",    32'(hp_o),    32'd2);
    check_eq("perfect_q",     32'(q_idx_o), 32'd3);
    check_eq("perfect_led",   32'(led_o),   32'd1);
    check_eq("perfect_state", 32'(state_o), 32'd4);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    check_eq("win_hold_state", 32'(state_o), 32'd4);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    // Two wrong answers lose the game.
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    answer(2'b10);
    answer(2'b10);
    check_eq("wrong_hp",    32'(hp_o),    32'd0);
    check_eq("wrong_over",  32'(go_o),    32'd1);
    check_eq("wrong_state", 32'(state_o), 32'd5);
    check_eq("wrong_q",     32'(q_idx_o), 32'd2);
    check_eq("wrong_count", 32'(count_o), 32'h00);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    // Timeout exactly TL cycles after QUE, then an invalid code.
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    repeat (TL - 1) idle();
    check_eq("to_before", 32'(state_o), 32'd2);
    idle();
    check_eq("to_judge", 32'(state_o), 32'd3);
    idle();
    check_eq("to_hp",    32'(hp_o),    32'd1);
    check_eq("to_state", 32'(state_o), 32'd1);
    answer(2'b11);
    check_eq("inval_hp",    32'(hp_o),    32'd0);
    check_eq("inval_state", 32'(state_o), 32'd5);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    // DEC coincident with TIMER=1 counts; final wrong answer loses, not wins.
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    repeat (TL - 1) idle();
    check_eq("edge_timer", 32'(timer_o), 32'd1);
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    idle();
    check_eq("edge_count", 32'(count_o), 32'h01);
    check_eq("edge_hp",    32'(hp_o),    32'd2);
    answer(2'b10);
    answer(2'b10);
    check_eq("last_state", 32'(state_o), 32'd5);
    check_eq("last_led",   32'(led_o),   32'd0);
    check_eq("last_over",  32'(go_o),    32'd1);
    check_eq("last_q",     32'(q_idx_o), 32'd3);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    // CLR while in INPUT.
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    answer(2'b01);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check_eq("clr_state", 32'(state_o), 32'd0);
    check_eq("clr_hp",    32'(hp_o),    32'd0);
    check_eq("clr_count", 32'(count_o), 32'h00);
    check_eq("clr_timer", 32'(timer_o), 32'd0);

    // Asynchronous RST mid-game, observed before the next clock edge.
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    answer(2'b01);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_hp",    32'(hp_o),    32'd0);
    check_eq("rst_count", 32'(count_o), 32'h00);
    check_eq("rst_timer", 32'(timer_o), 32'd0);
    model_reset();
    #2 rst = 1'b0;

    // Random play against the reference model.
    for (int n = 0; n < 2000; n++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 63) == 0));
    end

    // Score saturation on a 120-question, 2-digit game.
    s_step(1'b1, 1'b0, 1'b0, 2'b00);
    for (int i = 1; i <= 120; i++) begin
      s_step(1'b0, 1'b1, 1'b0, 2'b00);
      s_step(1'b0, 1'b0, 1'b1, 2'b01);
      s_step(1'b0, 1'b0, 1'b0, 2'b00);
      if (i == 10)  check_eq("sat_carry", 32'(s_count), 32'h10);
      if (i == 99)  check_eq("sat_99",    32'(s_count), 32'h99);
      if (i == 100) begin
        check_eq("sat_hold",  32'(s_count), 32'h99);
        check_eq("sat_state", 32'(s_state), 32'd1);
      end
    end
    check_eq("sat_count", 32'(s_count), 32'h99);
    check_eq("sat_q",     32'(s_q_idx), 32'd120);
    check_eq("sat_led",   32'(s_led),   32'd1);
    check_eq("sat_win",   32'(s_state), 32'd4);
    check_eq("sat_hp",    32'(s_hp),    32'd1);
    check_eq("sat_over",  32'(s_go),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quiz_seq.md
# quiz_seq

Parametrised game sequencer for the factorization quiz: runs a game of `NUM_Q` questions with `HP_INIT` hit points and a per-question answer time limit. It keeps the correct-answer score as a multi-digit BCD value and raises a win or lose indication. It sits between the board switch/button front end (READY, QUE, DEC, CLR) and the 7-segment/LED display logic, replacing the fixed-size counting inside the top-level join logic.

## Interface
Parameters:
- `NUM_Q`, 9: questions per game (1..255).
- `HP_INIT`, 3: hit points at game start (1..15).
- `CNT_DIGITS`, 3: BCD digits of the score counter.
- `TIME_LIMIT`, 1000: clock cycles allowed per answer (≥2).

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `READY`  in  1  level; starts a game from IDLE.
- `QUE`  in  1  one-cycle pulse; question shown, switch to input.
- `DEC`  in  1  one-cycle pulse; answer submitted, JUDG valid.
- `JUDG`  in  2  judgement, sampled only with DEC: 2'b01 correct, 2'b10 wrong, others invalid (treated as wrong).
- `CLR`  in  1  synchronous abort to IDLE; highest priority after RST.
- `STATE`  out  3  current state code.
- `HP`  out  4  remaining hit points.
- `Q_IDX`  out  8  questions completed, binary.
- `COUNT_OUT`  out  4*CNT_DIGITS  correct answers, BCD; digit 0 in LSBs.
- `TIMER`  out  clog2(TIME_LIMIT+1)  cycles left in INPUT.
- `LED`  out  1  game won.
- `GAME_OVER`  out  1  game lost.

## Operation
- States and codes: IDLE 0, WAIT_Q 1, INPUT 2, JUDGE 3, WIN 4, LOSE 5.
- IDLE: if READY=1, go to WAIT_Q. Load HP=HP_INIT, Q_IDX=0, COUNT_OUT=0.
- WAIT_Q: on QUE, go to INPUT and load TIMER=TIME_LIMIT. DEC is ignored in this state.
- INPUT: TIMER decrements by 1 each cycle.
  - On DEC: latch the verdict from JUDG and go to JUDGE.
  - On TIMER=1 without DEC: latch verdict "wrong" and go to JUDGE.
  - DEC in the same cycle as expiry: DEC wins.
  - QUE is ignored in this state.
- JUDGE (exactly one cycle):
  - Correct verdict: COUNT_OUT +1 in BCD, saturating at all nines.
  - Wrong verdict: HP −1, never below 0.
  - Q_IDX +1.
  - Next state: LOSE if the new HP=0; else WIN if the new Q_IDX=NUM_Q; else WAIT_Q. LOSE has priority over WIN on the final question.
- WIN: LED=1. LOSE: GAME_OVER=1. Both hold all counters and leave only on CLR.
- CLR in any state: go to IDLE. HP, Q_IDX, COUNT_OUT, TIMER, LED and GAME_OVER clear to 0.
- Reset: all outputs 0, STATE=IDLE. RST asserted mid-game discards all progress.
- TIMER reads 0 outside INPUT.

## Timing
- All outputs are registered.
- DEC high at edge k → STATE=JUDGE after k. COUNT_OUT/HP/Q_IDX update and STATE leaves JUDGE at edge k+1: 2-cycle latency from DEC to score.
- QUE at edge k → STATE=INPUT and TIMER=TIME_LIMIT after k. Timeout gives JUDGE after edge k+TIME_LIMIT.
- READY is sampled only in IDLE. Holding READY high after a game does not restart it until CLR.
- Back-to-back QUE/DEC pulses are legal. A pulse arriving while STATE=JUDGE is dropped.

## Structure
- Package `quiz_pkg`: state codes, JUDG codes (`JUDG_OK`, `JUDG_NG`), and the `TIMER` width function.
- Sub-module `bcd_counter` (parameter `DIGITS`; ports `CLK`, `RST`, `clr`, `inc`, `q`): ripple-carry BCD increment that saturates at all nines. One instance holds the score.
- Top: single FSM block plus HP, Q_IDX and TIMER registers.

## Test plan
Defaults unless stated: NUM_Q=3, HP_INIT=2, CNT_DIGITS=2, TIME_LIMIT=8.
- Perfect game: READY, then 3× (QUE, DEC with JUDG=01) → COUNT_OUT=8'h03, HP=2, Q_IDX=3, LED=1, STATE=4.
- Two wrong answers: (QUE, DEC JUDG=10) ×2 → HP=0, GAME_OVER=1, STATE=5, Q_IDX=2, COUNT_OUT=0.
- Timeout and invalid code: QUE with no DEC → JUDGE exactly 8 cycles later, HP=1. Next answer is DEC with JUDG=11 → HP=0, LOSE.
- DEC coincident with TIMER=1, JUDG=01 → counted correct, HP unchanged. Last question wrong dropping HP to 0 → LOSE, not WIN.
- Saturation (NUM_Q=120, HP_INIT=1, CNT_DIGITS=2): 120 correct answers → COUNT_OUT=8'h99, Q_IDX=120, WIN.
- Aborts: CLR in INPUT → IDLE with all outputs 0 next cycle. RST pulse mid-game → IDLE immediately, without waiting for a clock edge.
